// File: rtl/ram_arb_2m.sv
// Two-host arbiter (instruction fetch I, LSU data D) in front of the single-port 32-bit RAM.
// Optional macro RAM_ARB_RR_EN: round-robin on contention; default is fixed priority D over I.
module ram_arb_2m #(
  parameter int unsigned Depth    = 16384,
  parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,

  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic        ram_rvalid_i,
  input  logic [31:0] ram_rdata_i
);

  localparam logic [32:0] WinBytes = 33'(Depth) * 33'd4;

  logic        gnt_i, gnt_d, any_gnt;
  logic [31:0] sel_addr, sel_off;
  logic        in_range;
  logic        rsp_pend_q, rsp_own_q, rsp_err_q;
  logic        rsp_ok;
  logic [31:0] rsp_data;
  logic        unused_ram_rvalid;

  // The RAM answers exactly one cycle after every request, so rvalid carries no extra information.
  assign unused_ram_rvalid = ram_rvalid_i;

`ifdef RAM_ARB_RR_EN
  logic last_d_q;

  // On contention the host that was not served most recently wins.
  always_comb begin
    gnt_d = rst_ni & d_req_i & (~i_req_i | ~last_d_q);
    gnt_i = rst_ni & i_req_i & (~d_req_i | last_d_q);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_d_q <= 1'b0;
    end else if (any_gnt) begin
      last_d_q <= gnt_d;
    end
  end
`else
  always_comb begin
    gnt_d = rst_ni & d_req_i;
    gnt_i = rst_ni & i_req_i & ~d_req_i;
  end
`endif

  assign any_gnt = gnt_i | gnt_d;

  // Unsigned subtraction makes addresses below the base wrap to huge offsets (out of range).
  assign sel_addr = gnt_i ? i_addr_i : d_addr_i;
  assign sel_off  = sel_addr - BaseAddr;
  assign in_range = ({1'b0, sel_off} < WinBytes);

  assign i_gnt_o     = gnt_i;
  assign d_gnt_o     = gnt_d;
  assign ram_req_o   = any_gnt & in_range;
  assign ram_addr_o  = sel_off;
  assign ram_we_o    = gnt_d & d_we_i;
  assign ram_be_o    = gnt_i ? 4'hF : d_be_i;
  assign ram_wdata_o = gnt_i ? 32'h0 : d_wdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_pend_q <= 1'b0;
      rsp_own_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      rsp_pend_q <= any_gnt;
      if (any_gnt) begin
        rsp_own_q <= gnt_d;
        rsp_err_q <= ~in_range;
      end
    end
  end

  assign rsp_ok   = rst_ni & rsp_pend_q;
  assign rsp_data = rsp_err_q ? 32'h0 : ram_rdata_i;

  assign i_rvalid_o = rsp_ok & ~rsp_own_q;
  assign i_err_o    = i_rvalid_o & rsp_err_q;
  assign i_rdata_o  = i_rvalid_o ? rsp_data : 32'h0;

  assign d_rvalid_o = rsp_ok & rsp_own_q;
  assign d_err_o    = d_rvalid_o & rsp_err_q;
  assign d_rdata_o  = d_rvalid_o ? rsp_data : 32'h0;

endmodule

// File: tb/tb_ram_arb_2m.sv
// Bench for ram_arb_2m: directed scenarios, then random host traffic against a reference model.
module tb_ram_arb_2m;

  localparam int unsigned Depth = 16384;
  localparam logic [31:0] Base  = 32'h0010_0000;
  localparam logic [31:0] Win   = 32'(Depth) * 32'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        ram_req, ram_we, ram_rvalid;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  logic [31:0] env_mem   [Depth];
  logic [31:0] model_mem [Depth];

  int total = 0;
  int bad   = 0;

  // Reference model state: outstanding response and last-served host.
  bit          m_pend, m_own, m_err, m_wr, m_last_d;
  logic [31:0] m_data;
  bit          g_i, g_d;
  logic [3:0]  seq;

  always #5 clk = ~clk;

  ram_arb_2m #(
    .Depth    (Depth),
    .BaseAddr (Base)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .i_req_i      (i_req),
    .i_addr_i     (i_addr),
    .i_gnt_o      (i_gnt),
    .i_rvalid_o   (i_rvalid),
    .i_rdata_o    (i_rdata),
    .i_err_o      (i_err),
    .d_req_i      (d_req),
    .d_we_i       (d_we),
    .d_be_i       (d_be),
    .d_addr_i     (d_addr),
    .d_wdata_i    (d_wdata),
    .d_gnt_o      (d_gnt),
    .d_rvalid_o   (d_rvalid),
    .d_rdata_o    (d_rdata),
    .d_err_o      (d_err),
    .ram_req_o    (ram_req),
    .ram_we_o     (ram_we),
    .ram_be_o     (ram_be),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_rvalid_i (ram_rvalid),
    .ram_rdata_i  (ram_rdata)
  );

  function automatic logic [31:0] init_word(int idx);
    if (idx == 4) return 32'hDEAD_BEEF;
    if (idx == 8) return 32'hAAAA_BBBB;
    return (32'(idx) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Single-port RAM environment with one-cycle read latency.
  initial begin
    for (int k = 0; k < Depth; k++) env_mem[k] = init_word(k);
    ram_rvalid = 1'b0;
    ram_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      ram_rvalid <= ram_req;
      if (ram_req) begin
        ram_rdata <= env_mem[ram_addr[15:2]];
        if (ram_we) begin
          for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) env_mem[ram_addr[15:2]][8*b +: 8] = ram_wdata[8*b +: 8];
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      7:       return $urandom;
      8:       return Base - 32'(4 * $urandom_range(1, 16));
      9:       return ($urandom_range(0, 1) != 0) ? Base + Win : Base + Win - 32'd4;
      default: return Base + 32'(4 * $urandom_range(0, 63));
    endcase
  endfunction

  // Called just after a falling edge with inputs applied; checks the cycle, advances the model.
  task automatic do_cycle();
    bit          ei, ed, inr, ereq, iv, dv;
    logic [31:0] a, off, rexp;
    #1;
    ei = 1'b0;
    ed = 1'b0;
    if (rst_n) begin
      if (i_req && d_req) begin
`ifdef RAM_ARB_RR_EN
        if (m_last_d) ei = 1'b1;
        else ed = 1'b1;
`else
        ed = 1'b1;
`endif
      end else if (d_req) begin
        ed = 1'b1;
      end else if (i_req) begin
        ei = 1'b1;
      end
    end
    a    = ed ? d_addr : i_addr;
    off  = a - Base;
    inr  = off < Win;
    ereq = (ei || ed) && inr;

    check("i_gnt", 32'(i_gnt), 32'(ei));
    check("d_gnt", 32'(d_gnt), 32'(ed));
    check("ram_req", 32'(ram_req), 32'(ereq));
    if (ereq) begin
      check("ram_addr", ram_addr, off);
      check("ram_we", 32'(ram_we), 32'(ed && d_we));
      check("ram_be", 32'(ram_be), ed ? 32'(d_be) : 32'hF);
      check("ram_wdata", ram_wdata, ed ? d_wdata : 32'h0);
    end

    iv   = rst_n && m_pend && !m_own;
    dv   = rst_n && m_pend && m_own;
    rexp = m_err ? 32'h0 : m_data;
    check("i_rvalid", 32'(i_rvalid), 32'(iv));
    check("d_rvalid", 32'(d_rvalid), 32'(dv));
    check("i_err", 32'(i_err), 32'(iv && m_err));
    check("d_err", 32'(d_err), 32'(dv && m_err));
    if (!iv) check("i_rdata_idle", i_rdata, 32'h0);
    else if (m_err || !m_wr) check("i_rdata", i_rdata, rexp);
    if (!dv) check("d_rdata_idle", d_rdata, 32'h0);
    else if (m_err || !m_wr) check("d_rdata", d_rdata, rexp);

    if (rst_n) begin
      m_pend = ei || ed;
      if (ei || ed) begin
        m_own    = ed;
        m_err    = !inr;
        m_wr     = ed && d_we;
        m_last_d = ed;
        if (inr) begin
          m_data = model_mem[off[15:2]];
          if (ed && d_we) begin
            for (int b = 0; b < 4; b++) begin
              if (d_be[b]) model_mem[off[15:2]][8*b +: 8] = d_wdata[8*b +: 8];
            end
          end
        end
      end
    end else begin
      m_pend   = 1'b0;
      m_own    = 1'b0;
      m_err    = 1'b0;
      m_last_d = 1'b0;
    end
    g_i = ei;
    g_d = ed;
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < Depth; k++) model_mem[k] = init_word(k);
    m_pend = 1'b0; m_own = 1'b0; m_err = 1'b0; m_wr = 1'b0; m_last_d = 1'b0;
    m_data = 32'h0; g_i = 1'b0; g_d = 1'b0; seq = 4'h0;
    rst_n = 1'b0;
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    @(negedge clk);
    do_cycle();
    do_cycle();
    rst_n = 1'b1;
    do_cycle();

    // I alone reads offset 0x10.
    i_req = 1'b1; i_addr = Base + 32'h10;
    #1;
    check("tp_i_gnt", 32'(i_gnt), 32'h1);
    check("tp_i_ram_addr", ram_addr, 32'h10);
    do_cycle();
    i_req = 1'b0;
    #1;
    check("tp_i_rvalid", 32'(i_rvalid), 32'h1);
    check("tp_i_rdata", i_rdata, 32'hDEAD_BEEF);
    check("tp_i_err", 32'(i_err), 32'h0);
    do_cycle();

    // D partial write then read-back.
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = Base + 32'h20; d_wdata = 32'h1234_5678;
    #1;
    check("tp_d_we", 32'(ram_we), 32'h1);
    check("tp_d_be", 32'(ram_be), 32'h3);
    do_cycle();
    d_we = 1'b0; d_be = 4'hF;
    do_cycle();
    d_req = 1'b0;
    #1;
    check("tp_d_readback", d_rdata, 32'hAAAA_5678);
    do_cycle();

    // D out-of-range read.
    d_req = 1'b1; d_addr = Base + 32'h0001_0000;
    #1;
    check("tp_oor_gnt", 32'(d_gnt), 32'h1);
    check("tp_oor_ram_req", 32'(ram_req), 32'h0);
    do_cycle();
    d_req = 1'b0;
    #1;
    check("tp_oor_rvalid", 32'(d_rvalid), 32'h1);
    check("tp_oor_err", 32'(d_err), 32'h1);
    check("tp_oor_rdata", d_rdata, 32'h0);
    do_cycle();

    // Reset right after a D grant drops the pending response.
    d_req = 1'b1; d_addr = Base + 32'h40;
    do_cycle();
    d_req = 1'b0; i_req = 1'b1; i_addr = Base + 32'h44; rst_n = 1'b0;
    #1;
    check("tp_rst_d_rvalid", 32'(d_rvalid), 32'h0);
    check("tp_rst_i_gnt", 32'(i_gnt), 32'h0);
    do_cycle();
    do_cycle();
    rst_n = 1'b1; i_req = 1'b0;
    #1;
    check("tp_post_rst_d_rvalid", 32'(d_rvalid), 32'h0);
    do_cycle();

    // Four cycles of contention straight after reset.
    i_req = 1'b1; i_addr = Base + 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = Base + 32'h100;
    for (int c = 0; c < 4; c++) begin
      #1;
      seq[3-c] = d_gnt;
      do_cycle();
    end
`ifdef RAM_ARB_RR_EN
    check("tp_contend_seq", 32'(seq), 32'hA);
`else
    check("tp_contend_seq", 32'(seq), 32'hF);
`endif
    i_req = 1'b0; d_req = 1'b0;
    do_cycle();

    // Random traffic; a host holds its request until it is granted.
    for (int n = 0; n < 400; n++) begin
      if (!i_req || g_i) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = rand_addr();
      end
      if (!d_req || g_d) begin
        d_req   = ($urandom_range(0, 3) != 0);
        d_we    = ($urandom_range(0, 1) != 0);
        d_be    = 4'($urandom_range(1, 15));
        d_addr  = rand_addr();
        d_wdata = $urandom;
      end
      do_cycle();
    end
    i_req = 1'b0; d_req = 1'b0;
    do_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
